maze_move_sequencer: RTL
========================

# maze_move_sequencer

Sequences every player move in the maze game against the shared map ROM. It takes one-cycle move strobes from the input interface and arbitrates simultaneous directions. It bounds-checks the candidate cell, issues one map-row read, and tests the wall bit. It then commits or rejects the move and raises sticky lost/won status. It sits between the input interface and the map ROM and replaces the ad-hoc movement/collision logic, so that position, ROM address and collision stay coherent in a single clock domain.

## Interface
- MAP_W, 30, map columns = ROM word width; bit x of a row word is 1 for a wall
- MAP_H, 21, map rows = ROM depth; row address = y
- ADDRW, $clog2(MAP_H), ROM address width
- ROM_LAT, 1, ROM read latency in clocks (≥1), from registered address to valid data
- START_X, 0 / START_Y, 20, spawn cell
- GOAL_X, 29 / GOAL_Y, 0, exit cell
- clk  in  1  system clock (ClkPort domain)
- reset  in  1  one clock; reset is asynchronous and active-high
- restart  in  1  synchronous return to spawn; clears lost/won
- move_req  in  4  one-cycle strobes: [0] up (y−1), [1] down (y+1), [2] left (x−1), [3] right (x+1)
- rom_addr  out  ADDRW  registered row address to map ROM
- rom_data  in  MAP_W  row word from map ROM
- player_x_pos  out  8  committed column
- player_y_pos  out  8  committed row
- busy  out  1  move in flight; move_req is ignored while high
- move_done  out  1  one-cycle pulse when a fetched move resolves
- bump  out  1  one-cycle pulse when a move is rejected at the map edge
- lost  out  1  sticky; set on entering a wall cell
- won  out  1  sticky; set on reaching the goal cell

## Operation
- Reset values: player_x_pos=START_X, player_y_pos=START_Y, rom_addr=START_Y, busy=0, move_done=0, bump=0, lost=0, won=0, state IDLE.
- States: IDLE, WAIT, CHECK, HALT.
- IDLE: samples move_req when nonzero.
  - Fixed priority: bit0 > bit1 > bit2 > bit3. Only the winner is acted on; losers are dropped, not queued.
  - Candidate = current position ±1 on one axis.
  - Edge rejection: up at y=0, down at y=MAP_H−1, left at x=0, or right at x=MAP_W−1. Result: bump pulses next cycle, no ROM access, state stays IDLE, position unchanged.
  - Otherwise: latch cand_x and cand_y, set rom_addr←cand_y, busy←1, go to WAIT.
- WAIT: count ROM_LAT−1 further cycles (zero cycles when ROM_LAT=1), then go to CHECK.
- CHECK: evaluate rom_data[cand_x].
  - Wall (1): position unchanged, lost←1, move_done pulse, go to HALT.
  - Free (0): commit the candidate to player_x_pos and player_y_pos, move_done pulse.
    - If the candidate equals (GOAL_X, GOAL_Y): won←1, go to HALT.
    - Else: go to IDLE.
  - busy←0 in all cases.
- HALT: all move_req ignored; outputs hold; exit only via reset or restart.
- rom_addr tracks player_y_pos whenever idle, so an external reader of the row sees the current row.
- restart: takes priority over every state and over a simultaneous move_req.
  - Next cycle: all outputs take their reset values and state is IDLE.
  - An in-flight fetch is abandoned; no move_done is issued for it.
- Position arithmetic is 8-bit unsigned. Edge checks guarantee no wrap; the upper bits beyond the map range are always 0.

## Timing
- With ROM_LAT=1 and a request in cycle 0:
  - Cycle 1: rom_addr=cand_y and busy=1.
  - Cycle 2: rom_data valid and CHECK.
  - Cycle 3: new position, move_done=1, lost/won updated, busy=0.
  - Cycle 3: earliest cycle a new move_req is accepted.
- General request-to-commit latency is ROM_LAT+2 cycles.
- An edge bump pulses in cycle 1 and is acceptable again in cycle 1.
- move_done and bump never assert in the same cycle. Each is high for exactly one cycle.
- An async reset asserted mid-move clears state immediately, with no pulse on release.

## Test plan
- Reset, then move_req=4'b1000 with row 20 bit1=0 → cycle 3: x=1, y=20, move_done=1, busy high during cycles 1–2, rom_addr=20 in cycle 1.
- At spawn (0,20), move_req=4'b0100 (left) → bump=1 in cycle 1, no rom_addr change, position (0,20); repeat with down → bump, y stays 20.
- move_req=4'b1001 with row 19 bit0=0 → up wins, y=19, x=0; the right request is dropped.
- Move into a cell with a wall bit set → position unchanged, lost=1 sticky. The next 10 move strobes are ignored; restart → (0,20), lost=0 the next cycle.
- Step onto (29,0) → won=1 on the same cycle as move_done; further requests are ignored.
- ROM_LAT=2 build: latency of 4 cycles. Strobes during busy are dropped. restart asserted in WAIT → no move_done, state IDLE, position at spawn.

Source files
------------

// File: rtl/maze_move_sequencer.sv
// Player move sequencer: arbitrates move strobes, edge-checks the candidate cell,
// fetches its map row from the ROM, and commits or rejects the move with sticky lost/won.
module maze_move_sequencer #(
    parameter int unsigned MAP_W   = 30,
    parameter int unsigned MAP_H   = 21,
    parameter int unsigned ADDRW   = $clog2(MAP_H),
    parameter int unsigned ROM_LAT = 1,
    parameter int unsigned START_X = 0,
    parameter int unsigned START_Y = 20,
    parameter int unsigned GOAL_X  = 29,
    parameter int unsigned GOAL_Y  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [3:0]       move_req,
    output logic [ADDRW-1:0] rom_addr,
    input  logic [MAP_W-1:0] rom_data,
    output logic [7:0]       player_x_pos,
    output logic [7:0]       player_y_pos,
    output logic             busy,
    output logic             move_done,
    output logic             bump,
    output logic             lost,
    output logic             won
);

    localparam int unsigned XW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int unsigned CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, HALT} state_t;

    state_t           state, state_n;
    logic [7:0]       cand_x, cand_x_n, cand_y, cand_y_n;
    logic [CW-1:0]    wait_cnt, wait_cnt_n;
    logic [ADDRW-1:0] rom_addr_n;
    logic [7:0]       player_x_n, player_y_n;
    logic             busy_n, move_done_n, bump_n, lost_n, won_n;

    logic [7:0]       tgt_x, tgt_y;
    logic             at_edge, wall_hit, at_goal;

    // Fixed-priority direction pick (up > down > left > right) and its edge test
    always_comb begin
        tgt_x   = player_x_pos;
        tgt_y   = player_y_pos;
        at_edge = 1'b0;
        if (move_req[0]) begin
            at_edge = (player_y_pos == 8'd0);
            tgt_y   = player_y_pos - 8'd1;
        end else if (move_req[1]) begin
            at_edge = (player_y_pos == 8'(MAP_H - 1));
            tgt_y   = player_y_pos + 8'd1;
        end else if (move_req[2]) begin
            at_edge = (player_x_pos == 8'd0);
            tgt_x   = player_x_pos - 8'd1;
        end else if (move_req[3]) begin
            at_edge = (player_x_pos == 8'(MAP_W - 1));
            tgt_x   = player_x_pos + 8'd1;
        end
    end

    assign wall_hit = rom_data[cand_x[XW-1:0]];
    assign at_goal  = (cand_x == 8'(GOAL_X)) && (cand_y == 8'(GOAL_Y));

    // Next-state and registered-output logic; restart overrides everything
    always_comb begin
        state_n     = state;
        cand_x_n    = cand_x;
        cand_y_n    = cand_y;
        wait_cnt_n  = wait_cnt;
        rom_addr_n  = rom_addr;
        player_x_n  = player_x_pos;
        player_y_n  = player_y_pos;
        busy_n      = busy;
        move_done_n = 1'b0;
        bump_n      = 1'b0;
        lost_n      = lost;
        won_n       = won;

        if (restart) begin
            state_n    = IDLE;
            wait_cnt_n = '0;
            rom_addr_n = ADDRW'(START_Y);
            player_x_n = 8'(START_X);
            player_y_n = 8'(START_Y);
            busy_n     = 1'b0;
            lost_n     = 1'b0;
            won_n      = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    rom_addr_n = ADDRW'(player_y_pos);
                    if (move_req != 4'd0) begin
                        if (at_edge) begin
                            bump_n = 1'b1;
                        end else begin
                            cand_x_n   = tgt_x;
                            cand_y_n   = tgt_y;
                            rom_addr_n = ADDRW'(tgt_y);
                            busy_n     = 1'b1;
                            wait_cnt_n = '0;
                            state_n    = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == CW'(ROM_LAT - 1)) begin
                        state_n = CHECK;
                    end else begin
                        wait_cnt_n = wait_cnt + CW'(1);
                    end
                end
                CHECK: begin
                    busy_n      = 1'b0;
                    move_done_n = 1'b1;
                    if (wall_hit) begin
                        lost_n     = 1'b1;
                        rom_addr_n = ADDRW'(player_y_pos);
                        state_n    = HALT;
                    end else begin
                        player_x_n = cand_x;
                        player_y_n = cand_y;
                        if (at_goal) begin
                            won_n   = 1'b1;
                            state_n = HALT;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                HALT: begin
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cand_x       <= '0;
            cand_y       <= '0;
            wait_cnt     <= '0;
            rom_addr     <= ADDRW'(START_Y);
            player_x_pos <= 8'(START_X);
            player_y_pos <= 8'(START_Y);
            busy         <= 1'b0;
            move_done    <= 1'b0;
            bump         <= 1'b0;
            lost         <= 1'b0;
            won          <= 1'b0;
        end else begin
            state        <= state_n;
            cand_x       <= cand_x_n;
            cand_y       <= cand_y_n;
            wait_cnt     <= wait_cnt_n;
            rom_addr     <= rom_addr_n;
            player_x_pos <= player_x_n;
            player_y_pos <= player_y_n;
            busy         <= busy_n;
            move_done    <= move_done_n;
            bump         <= bump_n;
            lost         <= lost_n;
            won          <= won_n;
        end
    end

endmodule
